// File: rtl/can_tx_mailbox_sched.sv
// Transmit scheduler between the CAN register file and the protocol core.
// Offers the pending mailbox with the lowest latched ID, handles arbitration loss, bus-error retries and aborts.
//
// state  | meaning
// IDLE   | nothing offered; waits for any pending mailbox
// SELECT | one cycle: picks lowest-ID pending mailbox, latches sel_idx / sel_id
// REQ    | frame offered to the core, waiting for grant
// BUSY   | frame on the bus, waiting for done / err / arb_lost
module can_tx_mailbox_sched #(
    parameter int NUM_MB    = 4,
    parameter int IDW       = 11,
    parameter int MAX_RETRY = 8
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic [NUM_MB-1:0]          mb_req_i,
    input  logic [NUM_MB*IDW-1:0]      mb_id_i,
    input  logic [NUM_MB-1:0]          mb_abort_i,
    output logic                       core_req_o,
    output logic [IDW-1:0]             core_id_o,
    output logic [$clog2(NUM_MB)-1:0]  core_mb_o,
    input  logic                       core_gnt_i,
    input  logic                       core_done_i,
    input  logic                       core_arb_lost_i,
    input  logic                       core_err_i,
    output logic [NUM_MB-1:0]          mb_pending_o,
    output logic [NUM_MB-1:0]          mb_ok_o,
    output logic [NUM_MB-1:0]          mb_fail_o,
    output logic [NUM_MB-1:0]          mb_aborted_o,
    output logic                       busy_o,
    output logic                       irq_o
);

    localparam int IDXW = $clog2(NUM_MB);
    localparam int RW   = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_REQ    = 2'd2,
        ST_BUSY   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_MB-1:0] pending_q;
    logic [IDW-1:0]    id_q    [NUM_MB];
    logic [RW-1:0]     retry_q [NUM_MB];
    logic [IDXW-1:0]   sel_idx_q;
    logic [IDW-1:0]    sel_id_q;
    logic              abort_flag_q;
    logic [NUM_MB-1:0] ok_q, fail_q, abrt_q;
    logic              irq_q;

    logic [NUM_MB-1:0] cand;
    logic              win_vld;
    logic [IDXW-1:0]   win_idx;
    logic [IDW-1:0]    win_id;

    logic              res_any, res_done, res_err, res_arb;
    logic              hold_sel, abort_eff;
    logic [RW-1:0]     retry_next;
    logic              retire_limit;
    logic              retry_inc;
    logic [NUM_MB-1:0] pend_set, pend_clr, ok_d, fail_d, abrt_d;

    // Mailboxes being aborted this cycle are not eligible, so SELECT never latches a dying frame.
    always_comb begin
        cand    = pending_q & ~mb_abort_i;
        win_vld = 1'b0;
        win_idx = '0;
        win_id  = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (cand[i] && (!win_vld || (id_q[i] < win_id))) begin
                win_vld = 1'b1;
                win_idx = IDXW'(i);
                win_id  = id_q[i];
            end
        end
    end

    assign res_done = (state_q == ST_BUSY) && core_done_i;
    assign res_err  = (state_q == ST_BUSY) && !core_done_i && core_err_i;
    assign res_arb  = (state_q == ST_BUSY) && !core_done_i && !core_err_i && core_arb_lost_i;
    assign res_any  = res_done || res_err || res_arb;

    // A grant in the same cycle as an abort puts the frame on the bus, so the abort is deferred like in BUSY.
    assign hold_sel     = (state_q == ST_BUSY) || ((state_q == ST_REQ) && core_gnt_i);
    assign abort_eff    = abort_flag_q || mb_abort_i[sel_idx_q];
    assign retry_next   = retry_q[sel_idx_q] + 1'b1;
    assign retire_limit = (retry_next == RW'(MAX_RETRY));
    assign retry_inc    = res_err && !abort_eff;

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        ok_d     = '0;
        fail_d   = '0;
        abrt_d   = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (mb_abort_i[i] && pending_q[i] && !(hold_sel && (sel_idx_q == IDXW'(i)))) begin
                pend_clr[i] = 1'b1;
                abrt_d[i]   = 1'b1;
            end
            if (mb_req_i[i] && !pending_q[i] && !mb_abort_i[i]) begin
                pend_set[i] = 1'b1;
            end
            if (sel_idx_q == IDXW'(i)) begin
                if (res_done) begin
                    ok_d[i]     = 1'b1;
                    pend_clr[i] = 1'b1;
                end else if ((res_err || res_arb) && abort_eff) begin
                    abrt_d[i]   = 1'b1;
                    pend_clr[i] = 1'b1;
                end else if (res_err && retire_limit) begin
                    fail_d[i]   = 1'b1;
                    pend_clr[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                state_d = win_vld ? ST_REQ : ST_IDLE;
            end
            ST_REQ: begin
                if (core_gnt_i) begin
                    state_d = ST_BUSY;
                end else if (mb_abort_i[sel_idx_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (res_any) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        core_req_o = (state_q == ST_REQ);
        busy_o     = (state_q != ST_IDLE);
    end

    // Retry counter reaches MAX_RETRY at most once before the frame is retired, so it never wraps.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pending_q    <= '0;
            sel_idx_q    <= '0;
            sel_id_q     <= '0;
            abort_flag_q <= 1'b0;
            ok_q         <= '0;
            fail_q       <= '0;
            abrt_q       <= '0;
            irq_q        <= 1'b0;
            for (int i = 0; i < NUM_MB; i++) begin
                id_q[i]    <= '0;
                retry_q[i] <= '0;
            end
        end else begin
            pending_q <= (pending_q & ~pend_clr) | pend_set;
            for (int i = 0; i < NUM_MB; i++) begin
                if (pend_set[i]) begin
                    id_q[i]    <= mb_id_i[i*IDW +: IDW];
                    retry_q[i] <= '0;
                end
            end
            if (retry_inc) begin
                retry_q[sel_idx_q] <= retry_next;
            end
            if ((state_q == ST_SELECT) && win_vld) begin
                sel_idx_q <= win_idx;
                sel_id_q  <= win_id;
            end
            abort_flag_q <= hold_sel && !res_any && abort_eff;
            ok_q         <= ok_d;
            fail_q       <= fail_d;
            abrt_q       <= abrt_d;
            irq_q        <= |{ok_q, fail_q, abrt_q};
        end
    end

    assign core_id_o    = sel_id_q;
    assign core_mb_o    = sel_idx_q;
    assign mb_pending_o = pending_q;
    assign mb_ok_o      = ok_q;
    assign mb_fail_o    = fail_q;
    assign mb_aborted_o = abrt_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_can_tx_mailbox_sched.sv
// Bench for can_tx_mailbox_sched: priority table, hand-written corner sequences and a randomized
// run against a mailbox-level reference model.
module tb_can_tx_mailbox_sched;

    localparam int NMB = 4;
    localparam int IW  = 11;
    localparam int MR  = 3;

    logic                 wb_clk_i;
    logic                 wb_rst_ni;
    logic [NMB-1:0]       mb_req_i;
    logic [NMB*IW-1:0]    mb_id_i;
    logic [NMB-1:0]       mb_abort_i;
    logic                 core_req_o;
    logic [IW-1:0]        core_id_o;
    logic [1:0]           core_mb_o;
    logic                 core_gnt_i;
    logic                 core_done_i;
    logic                 core_arb_lost_i;
    logic                 core_err_i;
    logic [NMB-1:0]       mb_pending_o;
    logic [NMB-1:0]       mb_ok_o;
    logic [NMB-1:0]       mb_fail_o;
    logic [NMB-1:0]       mb_aborted_o;
    logic                 busy_o;
    logic                 irq_o;

    can_tx_mailbox_sched #(.NUM_MB(NMB), .IDW(IW), .MAX_RETRY(MR)) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_ni       (wb_rst_ni),
        .mb_req_i        (mb_req_i),
        .mb_id_i         (mb_id_i),
        .mb_abort_i      (mb_abort_i),
        .core_req_o      (core_req_o),
        .core_id_o       (core_id_o),
        .core_mb_o       (core_mb_o),
        .core_gnt_i      (core_gnt_i),
        .core_done_i     (core_done_i),
        .core_arb_lost_i (core_arb_lost_i),
        .core_err_i      (core_err_i),
        .mb_pending_o    (mb_pending_o),
        .mb_ok_o         (mb_ok_o),
        .mb_fail_o       (mb_fail_o),
        .mb_aborted_o    (mb_aborted_o),
        .busy_o          (busy_o),
        .irq_o           (irq_o)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  mask;
        logic [43:0] ids;
        int          n;
        logic [7:0]  order;
    } prio_vec_t;

    prio_vec_t vecs [6];

    bit        m_pend  [NMB];
    int        m_id    [NMB];
    int        m_retry [NMB];
    bit        m_abf;
    int        m_sel;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_reset();
        wb_rst_ni = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_ni = 1'b1;
        tick();
    endtask

    task automatic req(input logic [3:0] mask, input logic [43:0] ids);
        mb_req_i = mask;
        mb_id_i  = ids;
        tick();
        mb_req_i = '0;
    endtask

    task automatic abort(input logic [3:0] mask);
        mb_abort_i = mask;
        tick();
        mb_abort_i = '0;
    endtask

    task automatic wait_offer(input int mb, input logic [10:0] id, input string nm);
        int k;
        k = 0;
        while (!core_req_o && k < 20) begin
            tick();
            k++;
        end
        chk({nm, "_req"}, 64'(core_req_o), 64'd1);
        chk({nm, "_mb"},  64'(core_mb_o),  64'(mb));
        chk({nm, "_id"},  64'(core_id_o),  64'(id));
    endtask

    task automatic grant();
        core_gnt_i = 1'b1;
        tick();
        core_gnt_i = 1'b0;
    endtask

    task automatic result(input bit d, input bit e, input bit a);
        core_done_i     = d;
        core_err_i      = e;
        core_arb_lost_i = a;
        tick();
        core_done_i     = 1'b0;
        core_err_i      = 1'b0;
        core_arb_lost_i = 1'b0;
    endtask

    function automatic logic [3:0] m_pack();
        logic [3:0] p;
        for (int i = 0; i < NMB; i++) p[i] = m_pend[i];
        return p;
    endfunction

    function automatic int m_pick();
        int best;
        best = -1;
        for (int i = 0; i < NMB; i++)
            if (m_pend[i] && (best < 0 || m_id[i] < m_id[best])) best = i;
        return best;
    endfunction

    function automatic logic [43:0] rand_ids();
        logic [43:0] ids;
        for (int i = 0; i < NMB; i++)
            ids[i*IW +: IW] = ($urandom_range(0, 2) == 0) ? 11'($urandom_range(0, 3))
                                                           : 11'($urandom_range(0, 2047));
        return ids;
    endfunction

    initial begin
        logic [43:0] ids;
        logic [3:0]  rq, ab, exp_ab, exp_ok, exp_fail;
        logic [2:0]  rr;
        int          mb, best;

        wb_rst_ni       = 1'b0;
        mb_req_i        = '0;
        mb_id_i         = '0;
        mb_abort_i      = '0;
        core_gnt_i      = 1'b0;
        core_done_i     = 1'b0;
        core_arb_lost_i = 1'b0;
        core_err_i      = 1'b0;

        vecs[0] = '{mask: 4'b0001, ids: {11'h000, 11'h000, 11'h000, 11'h123}, n: 1, order: 8'h00};
        vecs[1] = '{mask: 4'b0111, ids: {11'h000, 11'h100, 11'h100, 11'h200}, n: 3, order: 8'h09};
        vecs[2] = '{mask: 4'b1111, ids: {11'h000, 11'h7FF, 11'h000, 11'h7FF}, n: 4, order: 8'h8D};
        vecs[3] = '{mask: 4'b1010, ids: {11'h04F, 11'h000, 11'h050, 11'h000}, n: 2, order: 8'h07};
        vecs[4] = '{mask: 4'b1111, ids: {11'h2AA, 11'h2AA, 11'h2AA, 11'h2AA}, n: 4, order: 8'hE4};
        vecs[5] = '{mask: 4'b1100, ids: {11'h7FE, 11'h001, 11'h000, 11'h000}, n: 2, order: 8'h0E};

        do_reset();
        chk("reset_outs", 64'({core_req_o, busy_o, irq_o, mb_pending_o, mb_ok_o, mb_fail_o,
                               mb_aborted_o, core_id_o, core_mb_o}), 64'd0);

        // Single mailbox with exact latency
        mb_req_i = 4'b0001;
        mb_id_i  = {33'd0, 11'h123};
        tick();
        mb_req_i = '0;
        chk("t1_pending", 64'(mb_pending_o), 64'h1);
        chk("t1_req_n1",  64'(core_req_o),   64'd0);
        tick();
        chk("t1_select",  64'({busy_o, core_req_o}), 64'b10);
        tick();
        chk("t1_req_n2",  64'(core_req_o), 64'd1);
        chk("t1_id",      64'(core_id_o),  64'h123);
        grant();
        chk("t1_busy",    64'({busy_o, core_req_o}), 64'b10);
        tick();
        result(1'b1, 1'b0, 1'b0);
        chk("t1_ok",      64'(mb_ok_o),      64'h1);
        chk("t1_pend0",   64'(mb_pending_o), 64'h0);
        chk("t1_idle",    64'(busy_o),       64'd0);
        tick();
        chk("t1_irq",     64'({irq_o, mb_ok_o}), 64'h10);

        // Priority table
        for (int v = 0; v < 6; v++) begin
            req(vecs[v].mask, vecs[v].ids);
            for (int j = 0; j < vecs[v].n; j++) begin
                mb = int'(vecs[v].order[2*j +: 2]);
                wait_offer(mb, vecs[v].ids[mb*IW +: IW], $sformatf("tbl%0d_%0d", v, j));
                grant();
                result(1'b1, 1'b0, 1'b0);
                chk($sformatf("tbl%0d_%0d_ok", v, j), 64'(mb_ok_o), 64'(4'b0001 << mb));
            end
            tick();
            chk($sformatf("tbl%0d_drained", v), 64'({busy_o, mb_pending_o}), 64'd0);
        end

        // Arbitration loss re-queues; lower ID overtakes; retry count untouched
        req(4'b0001, {33'd0, 11'h300});
        wait_offer(0, 11'h300, "t3_first");
        grant();
        req(4'b1000, {11'h050, 33'd0});
        result(1'b0, 1'b0, 1'b1);
        chk("t3_arb_pulses", 64'({mb_ok_o, mb_fail_o, mb_aborted_o}), 64'd0);
        chk("t3_arb_pend",   64'(mb_pending_o), 64'h9);
        wait_offer(3, 11'h050, "t3_mb3");
        grant();
        result(1'b1, 1'b0, 1'b0);
        for (int r = 0; r < MR; r++) begin
            wait_offer(0, 11'h300, $sformatf("t3_retry%0d", r));
            grant();
            result(1'b0, 1'b1, 1'b0);
            chk($sformatf("t3_fail%0d", r), 64'(mb_fail_o), (r == MR - 1) ? 64'h1 : 64'h0);
        end
        tick();

        // Bus errors up to the retry limit, irq one cycle after fail
        req(4'b0010, {22'd0, 11'h0AB, 11'd0});
        for (int r = 0; r < MR; r++) begin
            wait_offer(1, 11'h0AB, $sformatf("t4_offer%0d", r));
            grant();
            result(1'b0, 1'b1, 1'b0);
            chk($sformatf("t4_fail%0d", r), 64'(mb_fail_o),    (r == MR - 1) ? 64'h2 : 64'h0);
            chk($sformatf("t4_pend%0d", r), 64'(mb_pending_o), (r == MR - 1) ? 64'h0 : 64'h2);
            tick();
            chk($sformatf("t4_irq%0d", r),  64'(irq_o),        (r == MR - 1) ? 64'd1 : 64'd0);
        end

        // Aborts: non-selected pending, selected in BUSY then done / err, selected in REQ
        req(4'b0101, {11'd0, 11'h020, 11'd0, 11'h010});
        wait_offer(0, 11'h010, "t5a");
        grant();
        abort(4'b0100);
        chk("t5a_aborted", 64'(mb_aborted_o), 64'h4);
        chk("t5a_pend",    64'(mb_pending_o), 64'h1);
        result(1'b1, 1'b0, 1'b0);
        chk("t5a_ok",      64'(mb_ok_o),      64'h1);
        tick();

        req(4'b0010, {22'd0, 11'h111, 11'd0});
        wait_offer(1, 11'h111, "t5b");
        grant();
        abort(4'b0010);
        chk("t5b_deferred", 64'({mb_aborted_o, mb_pending_o}), 64'h02);
        result(1'b1, 1'b0, 1'b0);
        chk("t5b_ok",       64'({mb_ok_o, mb_aborted_o, mb_pending_o}), 64'h200);
        tick();

        req(4'b0010, {22'd0, 11'h111, 11'd0});
        wait_offer(1, 11'h111, "t5c");
        grant();
        abort(4'b0010);
        result(1'b0, 1'b1, 1'b0);
        chk("t5c_aborted",  64'({mb_fail_o, mb_aborted_o, mb_pending_o}), 64'h020);
        tick();

        req(4'b1000, {11'h077, 33'd0});
        wait_offer(3, 11'h077, "t5d");
        abort(4'b1000);
        chk("t5d_aborted",  64'({mb_aborted_o, mb_pending_o}), 64'h80);
        chk("t5d_req_drop", 64'({core_req_o, busy_o}), 64'd0);
        abort(4'b0001);
        chk("t5e_nonpend",  64'(mb_aborted_o), 64'h0);
        mb_req_i   = 4'b0001;
        mb_abort_i = 4'b0001;
        tick();
        mb_req_i   = '0;
        mb_abort_i = '0;
        chk("t5f_req_abort", 64'({mb_pending_o, mb_aborted_o}), 64'h0);
        result(1'b1, 1'b1, 1'b1);
        chk("t5g_res_idle",  64'({mb_ok_o, mb_fail_o, mb_aborted_o, busy_o}), 64'd0);
        grant();
        chk("t5h_gnt_idle",  64'(busy_o), 64'd0);

        // Re-request of a pending mailbox keeps the first latched ID
        req(4'b0011, {22'd0, 11'h200, 11'h300});
        wait_offer(1, 11'h200, "t5i");
        grant();
        req(4'b0001, {33'd0, 11'h100});
        result(1'b1, 1'b0, 1'b0);
        wait_offer(0, 11'h300, "t5i_keep");
        grant();
        result(1'b1, 1'b0, 1'b0);
        tick();

        // Reset in the middle of a frame
        req(4'b0001, {33'd0, 11'h123});
        wait_offer(0, 11'h123, "t6");
        grant();
        #2 wb_rst_ni = 1'b0;
        #1;
        chk("t6_rst_outs", 64'({core_req_o, busy_o, irq_o, mb_pending_o, mb_ok_o, mb_fail_o,
                                mb_aborted_o, core_id_o, core_mb_o}), 64'd0);
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b1;
        repeat (5) tick();
        chk("t6_no_offer", 64'({core_req_o, busy_o}), 64'd0);
        result(1'b1, 1'b0, 1'b0);
        chk("t6_no_ok",    64'(mb_ok_o), 64'd0);

        // Randomized run against the mailbox-level model
        do_reset();
        for (int i = 0; i < NMB; i++) begin
            m_pend[i]  = 1'b0;
            m_id[i]    = 0;
            m_retry[i] = 0;
        end
        for (int it = 0; it < 200; it++) begin
            if (m_pack() == 4'd0) begin
                rq  = 4'($urandom_range(1, 15));
                ids = rand_ids();
                req(rq, ids);
                for (int i = 0; i < NMB; i++)
                    if (rq[i]) begin
                        m_pend[i]  = 1'b1;
                        m_id[i]    = int'(ids[i*IW +: IW]);
                        m_retry[i] = 0;
                    end
            end
            best  = m_pick();
            m_sel = best;
            wait_offer(best, 11'(m_id[best]), $sformatf("rnd%0d", it));
            grant();
            m_abf = 1'b0;

            rq     = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
            ab     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            ids    = rand_ids();
            exp_ab = '0;
            for (int i = 0; i < NMB; i++) begin
                if (ab[i]) begin
                    if (m_pend[i]) begin
                        if (i == m_sel) m_abf = 1'b1;
                        else begin
                            m_pend[i] = 1'b0;
                            exp_ab[i] = 1'b1;
                        end
                    end
                end else if (rq[i] && !m_pend[i]) begin
                    m_pend[i]  = 1'b1;
                    m_id[i]    = int'(ids[i*IW +: IW]);
                    m_retry[i] = 0;
                end
            end
            mb_req_i   = rq;
            mb_abort_i = ab;
            mb_id_i    = ids;
            tick();
            mb_req_i   = '0;
            mb_abort_i = '0;
            chk($sformatf("rnd%0d_busy_ab", it),   64'(mb_aborted_o), 64'(exp_ab));
            chk($sformatf("rnd%0d_busy_pend", it), 64'(mb_pending_o), 64'(m_pack()));

            rr       = 3'($urandom_range(1, 7));
            exp_ok   = '0;
            exp_fail = '0;
            exp_ab   = '0;
            if (rr[0]) begin
                exp_ok[m_sel] = 1'b1;
                m_pend[m_sel] = 1'b0;
            end else if (rr[1] && !m_abf) begin
                m_retry[m_sel]++;
                if (m_retry[m_sel] == MR) begin
                    exp_fail[m_sel] = 1'b1;
                    m_pend[m_sel]   = 1'b0;
                end
            end else if (m_abf) begin
                exp_ab[m_sel] = 1'b1;
                m_pend[m_sel] = 1'b0;
            end
            result(rr[0], rr[1], rr[2]);
            chk($sformatf("rnd%0d_res", it), 64'({mb_ok_o, mb_fail_o, mb_aborted_o}),
                64'({exp_ok, exp_fail, exp_ab}));
            chk($sformatf("rnd%0d_pend", it), 64'(mb_pending_o), 64'(m_pack()));
            tick();
            chk($sformatf("rnd%0d_irq", it), 64'(irq_o), 64'(|{exp_ok, exp_fail, exp_ab}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
